// File: rtl/regfile_wr_arbiter.sv
// Write-port owner for the 2R1W register file: clears registers 1..DEPTH-1 after reset,
// then shares WE3/A3/WD3 between NREQ writeback sources with round-robin valid/ready arbitration.
module regfile_wr_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int DEPTH = 32,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  we3,
  output logic [AW-1:0]         a3,
  output logic [WIDTH-1:0]      wd3,
  output logic [IDW-1:0]        grant_id,
  output logic                  init_done
);

  // One extra bit so the wrapped distance (i + NREQ - rr_ptr) never overflows.
  localparam int DW = IDW + 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_reg;
  logic [AW-1:0]    init_ptr_reg;
  logic [IDW-1:0]   rr_ptr_reg;
  logic             we3_reg;
  logic [AW-1:0]    a3_reg;
  logic [WIDTH-1:0] wd3_reg;
  logic [IDW-1:0]   grant_id_reg;
  logic             init_done_reg;

  logic [AW-1:0]    addr_arr [NREQ];
  logic [WIDTH-1:0] data_arr [NREQ];
  logic [DW-1:0]    dist_arr [NREQ];
  logic [DW-1:0]    rr_ext;

  logic [NREQ-1:0]  grant_next;
  logic [IDW-1:0]   winner_next;
  logic [DW-1:0]    best_dist;
  logic             found;
  logic             arb_en;
  logic             transfer;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_data;
  logic [IDW-1:0]   rr_ptr_next;

  assign rr_ext = {1'b0, rr_ptr_reg};

  // Distance of each requester from the round-robin pointer, in search order.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign addr_arr[gi] = req_addr[gi*AW +: AW];
      assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
      assign dist_arr[gi] = (DW'(gi) >= rr_ext) ? (DW'(gi) - rr_ext)
                                                : (DW'(gi + NREQ) - rr_ext);
    end
  endgenerate

  assign arb_en = (state_reg == ST_RUN) && !hold;

  always_comb begin
    grant_next  = '0;
    winner_next = '0;
    best_dist   = '0;
    found       = 1'b0;
    sel_addr    = '0;
    sel_data    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && (!found || dist_arr[i] < best_dist)) begin
        found       = 1'b1;
        best_dist   = dist_arr[i];
        winner_next = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      grant_next[i] = arb_en && found && (winner_next == IDW'(i));
      sel_addr      = sel_addr | (addr_arr[i] & {AW{grant_next[i]}});
      sel_data      = sel_data | (data_arr[i] & {WIDTH{grant_next[i]}});
    end
  end

  assign req_ready   = grant_next;
  assign transfer    = |(req_valid & grant_next);
  assign rr_ptr_next = (winner_next == IDW'(NREQ - 1)) ? '0 : winner_next + IDW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_INIT;
      init_ptr_reg  <= AW'(1);
      rr_ptr_reg    <= '0;
      we3_reg       <= 1'b0;
      a3_reg        <= '0;
      wd3_reg       <= '0;
      grant_id_reg  <= '0;
      init_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          we3_reg      <= 1'b1;
          a3_reg       <= init_ptr_reg;
          wd3_reg      <= '0;
          init_ptr_reg <= init_ptr_reg + AW'(1);
          if (init_ptr_reg == AW'(DEPTH - 1)) begin
            state_reg     <= ST_RUN;
            init_done_reg <= 1'b1;
          end
        end
        ST_RUN: begin
          if (transfer) begin
            // Address 0 is consumed but never written.
            we3_reg      <= (sel_addr != '0);
            a3_reg       <= sel_addr;
            wd3_reg      <= sel_data;
            grant_id_reg <= winner_next;
            rr_ptr_reg   <= rr_ptr_next;
          end else begin
            we3_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_INIT;
      endcase
    end
  end

  assign we3       = we3_reg;
  assign a3        = a3_reg;
  assign wd3       = wd3_reg;
  assign grant_id  = grant_id_reg;
  assign init_done = init_done_reg;

endmodule
